ram_dualport_be: RTL and testbench
==================================

Name: ram_dualport_be

Overview:
- Next-generation true dual-port block RAM: byte-enable writes, selectable read latency (1 or 2), selectable read-during-write mode.
- Per-port read-valid strobes, write-collision detection and a hardware clear sequencer.
- Drop-in storage for FIFOs, frame buffers and register files where both ports run on one clock and software needs a fast memory wipe.

Parameters:
- RAM_ADDR_WIDTH, 8, address bits; depth = 2**RAM_ADDR_WIDTH
- RAM_DATA_WIDTH, 32, word width; must be a multiple of RAM_BYTE_WIDTH
- RAM_BYTE_WIDTH, 8, bits per byte lane; NB = RAM_DATA_WIDTH/RAM_BYTE_WIDTH
- RAM_RD_LATENCY, 1, 1 or 2 cycles from accepted access to out_data/out_valid
- RAM_RDW_MODE, 0, same-port read-during-write: 0 = write-first, 1 = read-first
- CLEAR_VALUE, 0, word written to every location by the clear sequence

Ports:
- in_clk  input  1  clock, all logic on rising edge
- in_rst  input  1  synchronous active-high reset
- in_clear  input  1  one-cycle request to start the clear sweep
- out_busy  output  1  high while the clear sweep runs
- in_en_a  input  1  port A access enable
- in_wr_a  input  1  port A write (qualified by in_en_a)
- in_be_a  input  NB  port A byte enables
- in_addr_a  input  RAM_ADDR_WIDTH  port A address
- in_data_a  input  RAM_DATA_WIDTH  port A write data
- out_data_a  output  RAM_DATA_WIDTH  port A read data
- out_valid_a  output  1  port A data valid strobe
- in_en_b, in_wr_b, in_be_b, in_addr_b, in_data_b, out_data_b, out_valid_b: port B, same widths and meaning
- out_collision  output  1  same-address overlapping-byte write strobe

Behaviour:
- Reset (in_rst=1 at edge):
  - out_data_a/b = 0, out_valid_a/b = 0, out_collision = 0, out_busy = 0; all pipeline stages cleared; FSM -> IDLE.
  - Memory contents untouched.
- Access is accepted when in_en_x=1 and FSM=IDLE. out_valid_x pulses exactly RAM_RD_LATENCY cycles later with out_data_x.
- out_data_x holds its last value when no access completes. out_valid_x is a one-cycle strobe per access.
- Read (wr=0): returns mem[addr].
- Write (wr=1): only bytes with be[i]=1 are updated. The access also returns data:
  - write-first: merged word (new bytes where be=1, old bytes elsewhere);
  - read-first: the old word.
  - wr=1 with be=0 is treated as a read.
- Cross-port same address, A writes while B reads (or vice versa): the reader gets the old word, in both modes.
- Both ports write the same address with (be_a & be_b) != 0:
  - port A wins the overlapping bytes; non-overlapping bytes from both ports are written;
  - out_collision pulses 1 cycle after the access edge (latency 1 regardless of RAM_RD_LATENCY).
- Same address with disjoint byte enables: no collision; both ports' bytes are written.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on in_clear=1; the clear counter loads 0.
  - In CLEAR, write CLEAR_VALUE to mem[cnt] each cycle and increment cnt. After cnt = 2**RAM_ADDR_WIDTH-1 is written, -> IDLE. Sweep takes exactly 2**RAM_ADDR_WIDTH cycles.
  - out_busy = 1 in every CLEAR cycle.
  - in_en_a/b are ignored during CLEAR (no writes, no valid strobes). in_clear is ignored during CLEAR.
  - Accesses already in the read pipeline when CLEAR starts complete normally.
- in_clear and in_en_x in the same IDLE cycle: the access is accepted, then the clear starts on the next cycle.
- in_rst during CLEAR: sweep aborts, FSM -> IDLE, memory is left partially cleared.
- RAM_RD_LATENCY=2 adds one output register stage per port, for data and valid together.

Decomposition:
- Package ram_pkg:
  - RDW mode constants (RDW_WRITE_FIRST=0, RDW_READ_FIRST=1);
  - FSM state encoding (ST_IDLE, ST_CLEAR);
  - function computing NB and the byte-merge of old/new words.
- Sub-module ram_rd_pipe: parametrised by width and latency; registers data and valid; synchronous reset. Instantiated once per port.
- Memory array, byte-write logic, collision detect and clear FSM live in the top module.

Test Plan (defaults unless stated):
- Reset, then A writes 0xDEADBEEF to 0x10 with be=1111; next cycle B reads 0x10 -> out_valid_b=1 one cycle later, out_data_b=0xDEADBEEF.
- mem[0x20]=0x11223344; A writes 0xAABBCCDD with be=0101 -> write-first returns 0x11BB33DD; read-first returns 0x11223344; later read gives 0x11BB33DD.
- Same cycle: A writes 0xAAAAAAAA, be=0011; B writes 0xBBBBBBBB, be=0110; both to 0x05 -> out_collision=1 one cycle later; mem[0x05] low byte 0xAA, byte1 0xAA, byte2 0xBB.
- RAM_RD_LATENCY=2: back-to-back reads of 0x00..0x03 on A -> four consecutive out_valid_a pulses starting 2 cycles after the first request, data in order.
- RAM_ADDR_WIDTH=4: pulse in_clear with en_a held high -> out_busy high exactly 16 cycles; no out_valid_a during the sweep; all 16 locations read back 0.
- in_rst asserted on cycle 5 of a clear -> out_busy=0 next cycle; addresses 0..4 read 0, address 8 keeps its prior value.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants, FSM encoding and byte-merge helper for the dual-port byte-enable RAM.
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Widest word the merge helper handles; callers cast in and out of this width.
    localparam int RAM_MAX_DW = 256;
    localparam int RAM_IDX_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_state_e;

    function automatic int ram_calc_nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic logic [RAM_MAX_DW-1:0] ram_merge(
        input logic [RAM_MAX_DW-1:0] old_w,
        input logic [RAM_MAX_DW-1:0] new_w,
        input logic [RAM_MAX_DW-1:0] be,
        input int                    byte_w
    );
        logic [RAM_MAX_DW-1:0] res;
        res = old_w;
        for (int j = 0; j < RAM_MAX_DW; j++) begin
            res[j] = be[RAM_IDX_W'(j / byte_w)] ? new_w[j] : old_w[j];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: one or two register stages carrying data and valid together.
module ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;

    // Data only advances with valid so the output holds between accesses.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) r_d1 <= in_data;
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;

            always_ff @(posedge in_clk) begin
                if (in_rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            end

            assign out_valid = r_v2;
            assign out_data  = r_d2;
        end else begin : g_lat1
            assign out_valid = r_v1;
            assign out_data  = r_d1;
        end
    endgenerate

endmodule

// File: rtl/ram_dualport_be.sv
// True dual-port byte-enable RAM with read-valid strobes, write-collision flag and a clear sweep.
module ram_dualport_be
    import ram_pkg::*;
#(
    parameter int                        RAM_ADDR_WIDTH = 8,
    parameter int                        RAM_DATA_WIDTH = 32,
    parameter int                        RAM_BYTE_WIDTH = 8,
    parameter int                        RAM_RD_LATENCY = 1,
    parameter int                        RAM_RDW_MODE   = RDW_WRITE_FIRST,
    parameter logic [RAM_DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                                     in_clk,
    input  logic                                     in_rst,
    input  logic                                     in_clear,
    output logic                                     out_busy,
    input  logic                                     in_en_a,
    input  logic                                     in_wr_a,
    input  logic [RAM_DATA_WIDTH/RAM_BYTE_WIDTH-1:0] in_be_a,
    input  logic [RAM_ADDR_WIDTH-1:0]                in_addr_a,
    input  logic [RAM_DATA_WIDTH-1:0]                in_data_a,
    output logic [RAM_DATA_WIDTH-1:0]                out_data_a,
    output logic                                     out_valid_a,
    input  logic                                     in_en_b,
    input  logic                                     in_wr_b,
    input  logic [RAM_DATA_WIDTH/RAM_BYTE_WIDTH-1:0] in_be_b,
    input  logic [RAM_ADDR_WIDTH-1:0]                in_addr_b,
    input  logic [RAM_DATA_WIDTH-1:0]                in_data_b,
    output logic [RAM_DATA_WIDTH-1:0]                out_data_b,
    output logic                                     out_valid_b,
    output logic                                     out_collision,
    output ram_state_e                               out_dbg_state
);

    localparam int NB    = ram_calc_nb(RAM_DATA_WIDTH, RAM_BYTE_WIDTH);
    localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;

    logic [RAM_DATA_WIDTH-1:0] r_mem [DEPTH];
    ram_state_e                r_state;
    logic [RAM_ADDR_WIDTH-1:0] r_cnt;
    logic                      r_busy;
    logic                      r_collision;

    logic                      w_idle, w_acc_a, w_acc_b, w_we_a, w_we_b, w_same;
    logic [NB-1:0]             w_be_ovl;
    logic [RAM_DATA_WIDTH-1:0] w_old_a, w_old_b, w_new_a, w_new_b;
    logic [RAM_DATA_WIDTH-1:0] w_wdata_a, w_rdata_a, w_rdata_b;

    // Handshake: an access is taken on any edge where in_en_x=1 while idle; there is
    // no back-pressure, and out_valid_x is a single-cycle strobe RAM_RD_LATENCY edges later.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_acc_a  = in_en_a && w_idle && !in_rst;
    assign w_acc_b  = in_en_b && w_idle && !in_rst;
    assign w_we_a   = w_acc_a && in_wr_a && (|in_be_a);
    assign w_we_b   = w_acc_b && in_wr_b && (|in_be_b);
    assign w_same   = (in_addr_a == in_addr_b);
    assign w_be_ovl = in_be_a & in_be_b;

    assign w_old_a = r_mem[in_addr_a];
    assign w_old_b = r_mem[in_addr_b];
    assign w_new_a = RAM_DATA_WIDTH'(ram_merge(RAM_MAX_DW'(w_old_a), RAM_MAX_DW'(in_data_a),
                                               RAM_MAX_DW'(in_be_a), RAM_BYTE_WIDTH));
    assign w_new_b = RAM_DATA_WIDTH'(ram_merge(RAM_MAX_DW'(w_old_b), RAM_MAX_DW'(in_data_b),
                                               RAM_MAX_DW'(in_be_b), RAM_BYTE_WIDTH));

    // On a shared address A is layered over B's merged word, so A owns overlapping bytes.
    assign w_wdata_a = (w_same && w_we_b)
        ? RAM_DATA_WIDTH'(ram_merge(RAM_MAX_DW'(w_new_b), RAM_MAX_DW'(in_data_a),
                                    RAM_MAX_DW'(in_be_a), RAM_BYTE_WIDTH))
        : w_new_a;

    assign w_rdata_a = (w_we_a && RAM_RDW_MODE == RDW_WRITE_FIRST) ? w_new_a : w_old_a;
    assign w_rdata_b = (w_we_b && RAM_RDW_MODE == RDW_WRITE_FIRST) ? w_new_b : w_old_b;

    always_ff @(posedge in_clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else begin
            if (w_we_b) r_mem[in_addr_b] <= w_new_b;
            if (w_we_a) r_mem[in_addr_a] <= w_wdata_a;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_we_a && w_we_b && w_same && (|w_be_ovl);
            case (r_state)
                ST_IDLE: begin
                    if (in_clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    ram_rd_pipe #(.DATA_WIDTH(RAM_DATA_WIDTH), .LATENCY(RAM_RD_LATENCY)) u_pipe_a (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_valid  (w_acc_a),
        .in_data   (w_rdata_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a)
    );

    ram_rd_pipe #(.DATA_WIDTH(RAM_DATA_WIDTH), .LATENCY(RAM_RD_LATENCY)) u_pipe_b (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_valid  (w_acc_b),
        .in_data   (w_rdata_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b)
    );

    assign out_busy      = r_busy;
    assign out_collision = r_collision;
    assign out_dbg_state = r_state;

endmodule

// File: tb/tb_ram_dualport_be.sv
// Directed bench: d0 = defaults, d1 = read-first, d2 = 16 words with 2-cycle read latency.
module tb_ram_dualport_be;
  import ram_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear;
  logic        en_a, wr_a, en_b, wr_b;
  logic [3:0]  be_a, be_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [1:0]  tgt;

  logic [31:0] dq_a [3], dq_b [3];
  logic        vl_a [3], vl_b [3], coll [3], busy [3];
  ram_state_e  st [3];

  logic [31:0] obs_data_a, obs_data_b;
  logic        obs_valid_a, obs_valid_b, obs_coll, obs_busy;
  ram_state_e  obs_st;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  ram_dualport_be dut0 (
    .in_clk(clk), .in_rst(rst), .in_clear(clear && tgt == 2'd0), .out_busy(busy[0]),
    .in_en_a(en_a && tgt == 2'd0), .in_wr_a(wr_a), .in_be_a(be_a), .in_addr_a(addr_a),
    .in_data_a(data_a), .out_data_a(dq_a[0]), .out_valid_a(vl_a[0]),
    .in_en_b(en_b && tgt == 2'd0), .in_wr_b(wr_b), .in_be_b(be_b), .in_addr_b(addr_b),
    .in_data_b(data_b), .out_data_b(dq_b[0]), .out_valid_b(vl_b[0]),
    .out_collision(coll[0]), .out_dbg_state(st[0])
  );

  ram_dualport_be #(.RAM_RDW_MODE(RDW_READ_FIRST)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_clear(clear && tgt == 2'd1), .out_busy(busy[1]),
    .in_en_a(en_a && tgt == 2'd1), .in_wr_a(wr_a), .in_be_a(be_a), .in_addr_a(addr_a),
    .in_data_a(data_a), .out_data_a(dq_a[1]), .out_valid_a(vl_a[1]),
    .in_en_b(en_b && tgt == 2'd1), .in_wr_b(wr_b), .in_be_b(be_b), .in_addr_b(addr_b),
    .in_data_b(data_b), .out_data_b(dq_b[1]), .out_valid_b(vl_b[1]),
    .out_collision(coll[1]), .out_dbg_state(st[1])
  );

  ram_dualport_be #(.RAM_ADDR_WIDTH(4), .RAM_RD_LATENCY(2)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_clear(clear && tgt == 2'd2), .out_busy(busy[2]),
    .in_en_a(en_a && tgt == 2'd2), .in_wr_a(wr_a), .in_be_a(be_a), .in_addr_a(addr_a[3:0]),
    .in_data_a(data_a), .out_data_a(dq_a[2]), .out_valid_a(vl_a[2]),
    .in_en_b(en_b && tgt == 2'd2), .in_wr_b(wr_b), .in_be_b(be_b), .in_addr_b(addr_b[3:0]),
    .in_data_b(data_b), .out_data_b(dq_b[2]), .out_valid_b(vl_b[2]),
    .out_collision(coll[2]), .out_dbg_state(st[2])
  );

  always_comb begin
    obs_data_a  = dq_a[0];
    obs_data_b  = dq_b[0];
    obs_valid_a = vl_a[0];
    obs_valid_b = vl_b[0];
    obs_coll    = coll[0];
    obs_busy    = busy[0];
    obs_st      = st[0];
    if (tgt == 2'd1) begin
      obs_data_a = dq_a[1]; obs_data_b = dq_b[1]; obs_valid_a = vl_a[1];
      obs_valid_b = vl_b[1]; obs_coll = coll[1]; obs_busy = busy[1]; obs_st = st[1];
    end else if (tgt == 2'd2) begin
      obs_data_a = dq_a[2]; obs_data_b = dq_b[2]; obs_valid_a = vl_a[2];
      obs_valid_b = vl_b[2]; obs_coll = coll[2]; obs_busy = busy[2]; obs_st = st[2];
    end
  end

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat();
    return (tgt == 2'd2) ? 2 : 1;
  endfunction

  task automatic idle_ports();
    en_a = 1'b0;
    en_b = 1'b0;
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic drive_a(input logic wr, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] data);
    en_a = 1'b1; wr_a = wr; be_a = be; addr_a = addr; data_a = data;
  endtask

  task automatic drive_b(input logic wr, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] data);
    en_b = 1'b1; wr_b = wr; be_b = be; addr_b = addr; data_b = data;
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [31:0] data);
    drive_a(1'b1, 4'hF, addr, data);
    tick();
    idle_ports();
    repeat (2) tick();
  endtask

  task automatic read_chk_a(input logic [7:0] addr, input logic [31:0] exp_v, input string tag);
    drive_a(1'b0, 4'hF, addr, 32'h0);
    tick();
    idle_ports();
    repeat (lat() - 1) tick();
    check_eq({tag, "_valid"}, {31'd0, obs_valid_a}, 32'd1);
    check_eq({tag, "_data"}, obs_data_a, exp_v);
    tick();
  endtask

  task automatic read_chk_b(input logic [7:0] addr, input logic [31:0] exp_v, input string tag);
    drive_b(1'b0, 4'hF, addr, 32'h0);
    tick();
    idle_ports();
    repeat (lat() - 1) tick();
    check_eq({tag, "_valid"}, {31'd0, obs_valid_b}, 32'd1);
    check_eq({tag, "_data"}, obs_data_b, exp_v);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int v_cnt;
    rst = 1'b1; clear = 1'b0; tgt = 2'd0;
    be_a = 4'h0; be_b = 4'h0; addr_a = 8'h0; addr_b = 8'h0; data_a = 32'h0; data_b = 32'h0;
    idle_ports();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_data_a", dq_a[k], 32'h0);
      check_eq("rst_valid_a", {31'd0, vl_a[k]}, 32'd0);
      check_eq("rst_data_b", dq_b[k], 32'h0);
      check_eq("rst_coll", {31'd0, coll[k]}, 32'd0);
      check_eq("rst_busy", {31'd0, busy[k]}, 32'd0);
      check_eq("rst_state", 32'(st[k]), 32'(ST_IDLE));
    end
    rst = 1'b0;
    tick();

    // d0: full write then cross-port read
    drive_a(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    tick();
    idle_ports();
    check_eq("wf_full_valid", {31'd0, obs_valid_a}, 32'd1);
    check_eq("wf_full_data", obs_data_a, 32'hDEADBEEF);
    drive_b(1'b0, 4'hF, 8'h10, 32'h0);
    tick();
    idle_ports();
    check_eq("strobe_one_cycle", {31'd0, obs_valid_a}, 32'd0);
    check_eq("data_hold", obs_data_a, 32'hDEADBEEF);
    check_eq("b_read_valid", {31'd0, obs_valid_b}, 32'd1);
    check_eq("b_read_data", obs_data_b, 32'hDEADBEEF);
    tick();

    // d0: partial write, write-first return
    write_a(8'h20, 32'h11223344);
    drive_a(1'b1, 4'b0101, 8'h20, 32'hAABBCCDD);
    tick();
    idle_ports();
    check_eq("wf_partial_ret", obs_data_a, 32'h11BB33DD);
    tick();
    read_chk_b(8'h20, 32'h11BB33DD, "wf_partial_mem");

    // d0: A writes while B reads the same word
    drive_a(1'b1, 4'hF, 8'h20, 32'hCAFEF00D);
    drive_b(1'b0, 4'hF, 8'h20, 32'h0);
    tick();
    idle_ports();
    check_eq("xport_old", obs_data_b, 32'h11BB33DD);
    check_eq("xport_no_coll", {31'd0, obs_coll}, 32'd0);
    tick();
    read_chk_a(8'h20, 32'hCAFEF00D, "xport_mem");

    // d0: overlapping write collision
    write_a(8'h05, 32'h12345678);
    drive_a(1'b1, 4'b0011, 8'h05, 32'hAAAAAAAA);
    drive_b(1'b1, 4'b0110, 8'h05, 32'hBBBBBBBB);
    tick();
    idle_ports();
    check_eq("coll_pulse", {31'd0, obs_coll}, 32'd1);
    tick();
    check_eq("coll_clear", {31'd0, obs_coll}, 32'd0);
    read_chk_a(8'h05, 32'h12BBAAAA, "coll_mem");

    // d0: same address, disjoint lanes
    write_a(8'h06, 32'h0);
    drive_a(1'b1, 4'b0001, 8'h06, 32'h111111AA);
    drive_b(1'b1, 4'b1000, 8'h06, 32'hBB222222);
    tick();
    idle_ports();
    check_eq("disjoint_no_coll", {31'd0, obs_coll}, 32'd0);
    tick();
    read_chk_b(8'h06, 32'hBB0000AA, "disjoint_mem");

    // d0: wr with no byte enables behaves as a read
    drive_a(1'b1, 4'b0000, 8'h06, 32'hFFFFFFFF);
    tick();
    idle_ports();
    check_eq("be0_valid", {31'd0, obs_valid_a}, 32'd1);
    check_eq("be0_ret", obs_data_a, 32'hBB0000AA);
    tick();
    read_chk_a(8'h06, 32'hBB0000AA, "be0_mem");

    // d1: read-first
    tgt = 2'd1;
    write_a(8'h20, 32'h11223344);
    drive_a(1'b1, 4'b0101, 8'h20, 32'hAABBCCDD);
    tick();
    idle_ports();
    check_eq("rf_ret_old", obs_data_a, 32'h11223344);
    tick();
    read_chk_a(8'h20, 32'h11BB33DD, "rf_mem");

    // d2: latency-2 burst
    tgt = 2'd2;
    for (int i = 0; i < 4; i++) write_a(8'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive_a(1'b0, 4'hF, 8'(i), 32'h0);
        exp_q.push_back(32'hA0 + 32'(i));
      end else begin
        idle_ports();
      end
      tick();
      check_eq("l2_valid", {31'd0, obs_valid_a}, (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
      if (obs_valid_a && exp_q.size() > 0) check_eq("l2_data", obs_data_a, exp_q.pop_front());
    end
    check_eq("l2_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_ports();
    tick();

    // d2: clear sweep with port A requesting throughout
    busy_cnt = 0;
    v_cnt = 0;
    clear = 1'b1;
    drive_a(1'b0, 4'hF, 8'h03, 32'h0);
    tick();
    clear = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (obs_busy) busy_cnt++;
      if (obs_valid_a) begin
        v_cnt++;
        check_eq("clr_inflight_data", obs_data_a, 32'hA3);
      end
      if (k == 3) check_eq("clr_state", 32'(obs_st), 32'(ST_CLEAR));
      if (!obs_busy) idle_ports();
      tick();
    end
    check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    check_eq("clr_valid_count", 32'(v_cnt), 32'd1);
    for (int i = 0; i < 16; i++) read_chk_a(8'(i), 32'h0, "clr_zero");

    // d2: reset during the sweep
    for (int i = 0; i < 6; i++) write_a(8'(i), 32'h55);
    write_a(8'h08, 32'h88);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, obs_busy}, 32'd0);
    check_eq("abort_state", 32'(obs_st), 32'(ST_IDLE));
    tick();
    for (int i = 0; i < 5; i++) read_chk_a(8'(i), 32'h0, "abort_cleared");
    read_chk_a(8'h05, 32'h55, "abort_kept5");
    read_chk_a(8'h08, 32'h88, "abort_kept8");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
